// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that serialises N_REQ write requests onto one shared register.
// Each grant occupies one WRITE cycle followed by at least one IDLE cycle.
`default_nettype none

module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_data,
  output logic [2:0]             last_id,
  output logic [15:0]            wr_count,
  output logic                   busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [2:0]       ptr;
  logic             win_vld;
  logic [2:0]       win_id;
  logic [WIDTH-1:0] win_data;

  // First set request found scanning upward from ptr, wrapping modulo N_REQ.
  always_comb begin : arbitrate
    int idx;
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!win_vld && ((req & (ONE_HOT0 << idx)) != '0)) begin
        win_vld  = 1'b1;
        win_id   = 3'(idx);
        win_data = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == WRITE);

  // Grant outputs are loaded on entry to WRITE, so they are high for the WRITE cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      reg_en   <= 1'b0;
      reg_data <= '0;
      last_id  <= '0;
      wr_count <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= '0;
      reg_en <= 1'b0;
      if (state == IDLE && win_vld) begin
        gnt      <= ONE_HOT0 << win_id;
        reg_en   <= 1'b1;
        reg_data <= win_data;
        last_id  <= win_id;
        wr_count <= wr_count + 16'd1;
      end
      if (state == WRITE) begin
        ptr <= (last_id == 3'(N_REQ-1)) ? 3'd0 : last_id + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter with hand-computed expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_reg_write_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         reg_en;
  logic [31:0]  reg_data;
  logic [2:0]   last_id;
  logic [15:0]  wr_count;
  logic         busy;

  int checks;
  int failures;

  reg_write_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .reg_en   (reg_en),
    .reg_data (reg_data),
    .last_id  (last_id),
    .wr_count (wr_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    #12;
    checks++;
    if (gnt !== 4'b0 || reg_en !== 1'b0 || busy !== 1'b0 || reg_data !== 32'h0 ||
        last_id !== 3'd0 || wr_count !== 16'd0) begin
      failures++;
      $display("FAIL reset: gnt=%b reg_en=%b busy=%b data=%h id=%0d cnt=%0d required all zero",
               gnt, reg_en, busy, reg_data, last_id, wr_count);
    end
    do_reset();
  endtask

  task automatic test_single();
    req_data[2*32 +: 32] = 32'hDEADBEEF;
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100 || reg_en !== 1'b1 || reg_data !== 32'hDEADBEEF ||
        last_id !== 3'd2 || wr_count !== 16'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_write: gnt=%b en=%b data=%h id=%0d cnt=%0d busy=%b required 0100 1 deadbeef 2 1 1",
               gnt, reg_en, reg_data, last_id, wr_count, busy);
    end
    req = 4'b0000;
    req_data[2*32 +: 32] = 32'h12345678;
    step();
    checks++;
    if (gnt !== 4'b0 || reg_en !== 1'b0 || busy !== 1'b0 ||
        reg_data !== 32'hDEADBEEF || last_id !== 3'd2 || wr_count !== 16'd1) begin
      failures++;
      $display("FAIL single_hold: gnt=%b en=%b busy=%b data=%h id=%0d cnt=%0d required 0000 0 0 deadbeef 2 1",
               gnt, reg_en, busy, reg_data, last_id, wr_count);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if (gnt !== (4'b0001 << j) || reg_data !== (32'hA000_0000 + 32'(j)) || last_id !== 3'(j)) begin
        failures++;
        $display("FAIL rr_grant%0d: gnt=%b data=%h id=%0d required %b %h %0d",
                 j, gnt, reg_data, last_id, 4'b0001 << j, 32'hA000_0000 + 32'(j), j);
      end
      req[j] = 1'b0;
      step();
      checks++;
      if (gnt !== 4'b0 || reg_en !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle%0d: gnt=%b en=%b required 0000 0", j, gnt, reg_en);
      end
    end
    checks++;
    if (wr_count !== 16'd4) begin
      failures++;
      $display("FAIL rr_count: wr_count=%0d required 4", wr_count);
    end
  endtask

  // Grants an ordered pair of requesters from a two-bit request mask.
  task automatic grant_pair(input logic [3:0] mask, input int first, input int second, input string name);
    req = mask;
    step();
    checks++;
    if (gnt !== (4'b0001 << first) || last_id !== 3'(first)) begin
      failures++;
      $display("FAIL %s_first: gnt=%b id=%0d required %b %0d", name, gnt, last_id, 4'b0001 << first, first);
    end
    req[first] = 1'b0;
    step();
    step();
    checks++;
    if (gnt !== (4'b0001 << second) || last_id !== 3'(second)) begin
      failures++;
      $display("FAIL %s_second: gnt=%b id=%0d required %b %0d", name, gnt, last_id, 4'b0001 << second, second);
    end
    req[second] = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    grant_pair(4'b1001, 0, 3, "wrap");
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    grant_pair(4'b0011, 0, 1, "ptr2");
    checks++;
    if (wr_count !== 16'd9) begin
      failures++;
      $display("FAIL wrap_count: wr_count=%0d required 9", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_en;
    prev_en = 1'b0;
    req = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (gnt !== ((k % 2 == 0) ? 4'b0010 : 4'b0000) || reg_en !== (k % 2 == 0) || (prev_en && reg_en)) begin
        failures++;
        $display("FAIL b2b_cycle%0d: gnt=%b en=%b required %b", k, gnt, reg_en, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      end
      prev_en = reg_en;
    end
    req = 4'b0000;
    step();
    checks++;
    if (wr_count !== 16'd13 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL b2b_count: wr_count=%0d gnt=%b required 13 0000", wr_count, gnt);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100 || reg_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: gnt=%b en=%b required 0100 1", gnt, reg_en);
    end
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0 || reg_en !== 1'b0 || busy !== 1'b0 || wr_count !== 16'd0 || reg_data !== 32'h0) begin
      failures++;
      $display("FAIL abort_async: gnt=%b en=%b busy=%b cnt=%0d data=%h required all zero",
               gnt, reg_en, busy, wr_count, reg_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010 || last_id !== 3'd1 || wr_count !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_ptr: gnt=%b id=%0d cnt=%0d required 0010 1 1", gnt, last_id, wr_count);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_count_wrap();
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    req_data[3*32 +: 32] = 32'hCAFE_0003;
    req = 4'b1000;
    step();
    req = 4'b0000;
    checks++;
    if (wr_count !== 16'hFFFF || gnt !== 4'b1000) begin
      failures++;
      $display("FAIL cnt_ffff: wr_count=%h gnt=%b required ffff 1000", wr_count, gnt);
    end
    step();
    req = 4'b1000;
    step();
    req = 4'b0000;
    checks++;
    if (wr_count !== 16'h0000 || gnt !== 4'b1000 || reg_data !== 32'hCAFE_0003 || last_id !== 3'd3) begin
      failures++;
      $display("FAIL cnt_wrap: wr_count=%h gnt=%b data=%h id=%0d required 0000 1000 cafe0003 3",
               wr_count, gnt, reg_data, last_id);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
